// File: rtl/manch_frame_enc.sv
// Manchester frame encoder: accepts a word over valid/ready and serialises it
// at a programmable bit rate as preamble, data bits and an idle guard gap.
module manch_frame_enc #(
  parameter int DATA_W   = 8,
  parameter int HALF_BIT = 4,
  parameter int PRE_LEN  = 4,
  parameter logic [((PRE_LEN > 0) ? PRE_LEN : 1)-1:0] PRE_PAT = 4'b1111,
  parameter int GAP_BITS = 1,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_LVL  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_mode,
  input  logic              in_abort,
  output logic              out_data,
  output logic              out_enable,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PW   = (PRE_LEN > 0) ? PRE_LEN : 1;
  localparam int unsigned HCW  = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
  localparam int unsigned MAXB = (PRE_LEN > DATA_W)
                                 ? ((PRE_LEN > GAP_BITS) ? PRE_LEN : GAP_BITS)
                                 : ((DATA_W > GAP_BITS) ? DATA_W : GAP_BITS);
  localparam int unsigned BCW  = $clog2(MAXB + 1);

  localparam logic [HCW-1:0] HALF_LAST = HCW'(HALF_BIT - 1);
  localparam logic [BCW-1:0] PRE_LAST  = BCW'((PRE_LEN > 0) ? PRE_LEN - 1 : 0);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_W - 1);
  localparam logic [BCW-1:0] GAP_LAST  = BCW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]        state, state_n;
  logic [HCW-1:0]    half_cnt, half_n;
  logic              phase, phase_n;
  logic [BCW-1:0]    bit_cnt, bit_n;
  logic [DATA_W-1:0] data_sr, data_sr_n;
  logic [PW-1:0]     pre_sr, pre_sr_n;
  logic              mode_q, mode_n;
  logic              out_n, oen_n, done_n, ready_n;
  logic              accept, half_end, last_bit, cur_bit, first_lvl;

  // Next-state, counter and line-level decode
  always_comb begin
    state_n   = state;
    half_n    = half_cnt;
    phase_n   = phase;
    bit_n     = bit_cnt;
    data_sr_n = data_sr;
    pre_sr_n  = pre_sr;
    mode_n    = mode_q;
    out_n     = IDLE_LVL;
    oen_n     = 1'b0;
    done_n    = 1'b0;
    ready_n   = 1'b0;
    accept    = in_valid & in_ready;
    half_end  = (half_cnt == HALF_LAST);
    cur_bit   = (state == S_PRE) ? pre_sr[PW-1]
                                 : (MSB_FIRST ? data_sr[DATA_W-1] : data_sr[0]);
    // IEEE sends ~bit first, Thomas sends bit first
    first_lvl = ~(cur_bit ^ mode_q);
    case (state)
      S_PRE:   last_bit = (bit_cnt == PRE_LAST);
      S_DATA:  last_bit = (bit_cnt == DATA_LAST);
      S_GAP:   last_bit = (bit_cnt == GAP_LAST);
      default: last_bit = 1'b0;
    endcase

    if (state == S_IDLE) begin
      ready_n = ~accept;
      if (accept) begin
        data_sr_n = in_data;
        pre_sr_n  = PRE_PAT;
        mode_n    = in_mode;
        half_n    = '0;
        phase_n   = 1'b0;
        bit_n     = '0;
        state_n   = (PRE_LEN > 0) ? S_PRE : S_DATA;
      end
    end else if (in_abort) begin
      state_n = S_IDLE;
      half_n  = '0;
      phase_n = 1'b0;
      bit_n   = '0;
      ready_n = 1'b1;
    end else begin
      if (state != S_GAP) begin
        out_n = phase ? ~first_lvl : first_lvl;
        oen_n = 1'b1;
      end
      if (half_end) begin
        half_n  = '0;
        phase_n = ~phase;
      end else begin
        half_n = half_cnt + HCW'(1);
      end
      // End of a full bit period: advance shifter and bit counter
      if (half_end && phase) begin
        if (state == S_PRE) begin
          pre_sr_n = pre_sr << 1;
        end else if (state == S_DATA) begin
          data_sr_n = MSB_FIRST ? (data_sr << 1) : (data_sr >> 1);
        end
        if (last_bit) begin
          bit_n = '0;
          case (state)
            S_PRE:   state_n = S_DATA;
            S_DATA:  state_n = (GAP_BITS > 0) ? S_GAP : S_IDLE;
            default: state_n = S_IDLE;
          endcase
          done_n = (state_n == S_IDLE);
        end else begin
          bit_n = bit_cnt + BCW'(1);
        end
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      half_cnt   <= '0;
      phase      <= 1'b0;
      bit_cnt    <= '0;
      data_sr    <= '0;
      pre_sr     <= '0;
      mode_q     <= 1'b0;
      out_data   <= IDLE_LVL;
      out_enable <= 1'b0;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      half_cnt   <= half_n;
      phase      <= phase_n;
      bit_cnt    <= bit_n;
      data_sr    <= data_sr_n;
      pre_sr     <= pre_sr_n;
      mode_q     <= mode_n;
      out_data   <= out_n;
      out_enable <= oen_n;
      in_ready   <= ready_n;
      busy       <= ~ready_n;
      done       <= done_n;
    end
  end

endmodule

// File: tb/tb_manch_frame_enc.sv
// Bench for manch_frame_enc: frame-level model compared every cycle, plus
// hand-computed waveform points for two parameter sets.
module tb_manch_frame_enc;

  logic clk = 1'b0;
  logic rst;
  logic v0, v1, m0, m1, a0, a1;
  logic [7:0] d0, d1;
  logic r0, r1, o0, o1, e0, e1, b0, b1, dn0, dn1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  int done_cnt0 = 0;

  always #5 clk = ~clk;

  manch_frame_enc u_def (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_data(d0),
    .in_mode(m0), .in_abort(a0), .out_data(o0), .out_enable(e0),
    .busy(b0), .done(dn0)
  );

  manch_frame_enc #(
    .DATA_W(8), .HALF_BIT(1), .PRE_LEN(0), .PRE_PAT(1'b0),
    .GAP_BITS(0), .MSB_FIRST(1'b0), .IDLE_LVL(1'b0)
  ) u_fast (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_data(d1),
    .in_mode(m1), .in_abort(a1), .out_data(o1), .out_enable(e1),
    .busy(b1), .done(dn1)
  );

  // Frame model: per instance, whether a frame is live, its accept edge, word, mode
  bit         act [2];
  int         n0  [2];
  logic [7:0] w   [2];
  logic       mm  [2];

  function automatic int hb_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction
  function automatic int pl_of(input int i);
    return (i == 0) ? 4 : 0;
  endfunction
  function automatic int t_of(input int i);
    return (i == 0) ? (4 + 8 + 1) * 2 * 4 : (0 + 8 + 0) * 2 * 1;
  endfunction
  function automatic int l_of(input int i);
    return (i == 0) ? (4 + 8) * 2 * 4 : 8 * 2 * 1;
  endfunction

  // Line level d cycles after the accept edge (d >= 1, inside preamble/data)
  function automatic logic exp_line(input int i, input logic [7:0] wd,
                                    input logic md, input int d);
    logic [3:0] pat;
    int idx, b, hf, j;
    logic bt, first;
    pat = 4'b1111;
    idx = d - 1;
    b   = idx / (2 * hb_of(i));
    hf  = (idx / hb_of(i)) % 2;
    if (b < pl_of(i)) begin
      bt = pat[pl_of(i) - 1 - b];
    end else begin
      j  = b - pl_of(i);
      bt = (i == 0) ? wd[7 - j] : wd[j];
    end
    first = md ? bt : ~bt;
    return (hf != 0) ? ~first : first;
  endfunction

  always @(posedge clk) begin
    logic vi, ai, mi;
    logic [7:0] di;
    int d;
    bit rdy;
    for (int i = 0; i < 2; i++) begin
      vi = (i == 0) ? v0 : v1;
      ai = (i == 0) ? a0 : a1;
      mi = (i == 0) ? m0 : m1;
      di = (i == 0) ? d0 : d1;
      d   = cyc - n0[i];
      rdy = !act[i] || (d > t_of(i));
      if (rst) begin
        act[i] = 1'b0;
      end else begin
        if (act[i] && ai && d < t_of(i)) act[i] = 1'b0;
        if (rdy && vi) begin
          act[i] = 1'b1;
          n0[i]  = cyc + 1;
          w[i]   = di;
          mm[i]  = mi;
        end
      end
    end
    cyc = cyc + 1;
  end

  task automatic cmp(input int i, input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL inst%0d %s cycle %0d: got %0b expected %0b", i, nm, cyc, got, exp);
    end
  endtask

  task automatic cmp_inst(input int i, input logic rr, input logic bb,
                          input logic oo, input logic ee, input logic dd);
    int d;
    logic xr, xb, xo, xe, xd;
    xr = 1'b1; xb = 1'b0; xo = 1'b0; xe = 1'b0; xd = 1'b0;
    d = cyc - n0[i];
    if (act[i] && d <= t_of(i)) begin
      xr = 1'b0;
      xb = 1'b1;
      xd = (d == t_of(i));
      if (d >= 1 && d <= l_of(i)) begin
        xe = 1'b1;
        xo = exp_line(i, w[i], mm[i], d);
      end
    end
    cmp(i, "in_ready", rr, xr);
    cmp(i, "busy", bb, xb);
    cmp(i, "out_data", oo, xo);
    cmp(i, "out_enable", ee, xe);
    cmp(i, "done", dd, xd);
  endtask

  always @(negedge clk) begin
    if (dn0 === 1'b1) done_cnt0++;
    if (chk_en) begin
      cmp_inst(0, r0, b0, o0, e0, dn0);
      cmp_inst(1, r1, b1, o1, e1, dn1);
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lit(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL lit %s cycle %0d: got %0b expected %0b", nm, cyc, got, exp);
    end
  endtask

  task automatic send0(input logic [7:0] wd, input logic md, output int n);
    v0 = 1'b1; d0 = wd; m0 = md;
    n = cyc + 1;
    wait_cyc(n);
    v0 = 1'b0;
  endtask

  initial begin
    int n, n2, dc;
    act[0] = 1'b0; act[1] = 1'b0; n0[0] = 0; n0[1] = 0;
    rst = 1'b1;
    v0 = 1'b0; v1 = 1'b0; m0 = 1'b0; m1 = 1'b0; a0 = 1'b0; a1 = 1'b0;
    d0 = 8'h00; d1 = 8'h00;
    #1;
    wait_cyc(3);
    rst = 1'b0;
    lit("rst_ready0", r0, 1'b1);  lit("rst_busy0", b0, 1'b0);
    lit("rst_out0", o0, 1'b0);    lit("rst_en0", e0, 1'b0);
    lit("rst_done0", dn0, 1'b0);  lit("rst_ready1", r1, 1'b1);
    chk_en = 1'b1;
    wait_cyc(6);

    // A5, IEEE
    send0(8'hA5, 1'b0, n);
    wait_cyc(n + 1);   lit("a5_pre_l", o0, 1'b0); lit("a5_en", e0, 1'b1);
    wait_cyc(n + 5);   lit("a5_pre_h", o0, 1'b1);
    wait_cyc(n + 33);  lit("a5_b7_l", o0, 1'b0);
    wait_cyc(n + 37);  lit("a5_b7_h", o0, 1'b1);
    wait_cyc(n + 41);  lit("a5_b6_h", o0, 1'b1);
    wait_cyc(n + 45);  lit("a5_b6_l", o0, 1'b0);
    wait_cyc(n + 103); lit("a5_nodone", dn0, 1'b0);
    wait_cyc(n + 104); lit("a5_done", dn0, 1'b1); lit("a5_rdy_lo", r0, 1'b0);
    wait_cyc(n + 105); lit("a5_rdy", r0, 1'b1); lit("a5_done_lo", dn0, 1'b0);
    wait_cyc(n + 110);

    // A5, Thomas
    send0(8'hA5, 1'b1, n);
    wait_cyc(n + 1);   lit("a5t_pre_h", o0, 1'b1);
    wait_cyc(n + 33);  lit("a5t_b7_h", o0, 1'b1);
    wait_cyc(n + 104); lit("a5t_done", dn0, 1'b1);
    wait_cyc(n + 110);

    // Fast instance, LSB first, no preamble or gap
    v1 = 1'b1; d1 = 8'h01; m1 = 1'b0;
    n = cyc + 1;
    wait_cyc(n);
    v1 = 1'b0;
    wait_cyc(n + 1);  lit("f_b0_l", o1, 1'b0);
    wait_cyc(n + 2);  lit("f_b0_h", o1, 1'b1);
    wait_cyc(n + 3);  lit("f_b1_h", o1, 1'b1);
    wait_cyc(n + 4);  lit("f_b1_l", o1, 1'b0);
    wait_cyc(n + 16); lit("f_done", dn1, 1'b1);
    wait_cyc(n + 17); lit("f_rdy", r1, 1'b1); lit("f_en_off", e1, 1'b0);
    wait_cyc(n + 20);

    // Back-to-back with in_valid held; data/mode change mid-frame
    v0 = 1'b1; d0 = 8'h3C; m0 = 1'b0;
    n = cyc + 1;
    wait_cyc(n + 50);
    d0 = 8'hC3; m0 = 1'b1;
    wait_cyc(n + 104); lit("bb_done", dn0, 1'b1);
    wait_cyc(n + 105); lit("bb_rdy", r0, 1'b1); lit("bb_idle_busy", b0, 1'b0);
    wait_cyc(n + 106); lit("bb_acc_busy", b0, 1'b1); lit("bb_acc_rdy", r0, 1'b0);
    lit("bb_en_lo", e0, 1'b0);
    v0 = 1'b0;
    wait_cyc(n + 107); lit("bb_en_hi", e0, 1'b1); lit("bb_pre_t", o0, 1'b1);
    wait_cyc(n + 106 + 110);

    // Abort during data bit 3
    send0(8'h5A, 1'b0, n);
    wait_cyc(n + 59);
    lit("ab_live", e0, 1'b1);
    a0 = 1'b1;
    wait_cyc(n + 60);
    a0 = 1'b0;
    lit("ab_out", o0, 1'b0); lit("ab_en", e0, 1'b0); lit("ab_busy", b0, 1'b0);
    lit("ab_rdy", r0, 1'b1); lit("ab_done", dn0, 1'b0);
    dc = done_cnt0;
    wait_cyc(n + 130);
    checks++;
    if (done_cnt0 != dc) begin
      errors++;
      $display("FAIL lit ab_no_done: got %0d pulses expected 0", done_cnt0 - dc);
    end

    // Reset mid-preamble, then a clean restart
    send0(8'hF0, 1'b0, n);
    wait_cyc(n + 10);
    rst = 1'b1;
    wait_cyc(n + 11);
    rst = 1'b0;
    lit("mr_rdy", r0, 1'b1); lit("mr_busy", b0, 1'b0); lit("mr_out", o0, 1'b0);
    lit("mr_en", e0, 1'b0);  lit("mr_done", dn0, 1'b0);
    wait_cyc(n + 14);
    send0(8'h0F, 1'b1, n2);
    wait_cyc(n2 + 104); lit("mr2_done", dn0, 1'b1);
    wait_cyc(n2 + 110);

    // Abort in IDLE is ignored; accept in the same cycle goes ahead
    v0 = 1'b1; a0 = 1'b1; d0 = 8'h81; m0 = 1'b0;
    n = cyc + 1;
    wait_cyc(n);
    v0 = 1'b0; a0 = 1'b0;
    lit("ia_busy", b0, 1'b1); lit("ia_rdy", r0, 1'b0);
    wait_cyc(n + 1); lit("ia_en", e0, 1'b1);
    wait_cyc(n + 110);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
